// File: rtl/pool2_flat_read_arbiter.sv
// pool2_flat_read_arbiter
//   Shares the byte-addressed read port of the pool-2 flattened output buffer
//   between the dense-layer engine and the RISC-V MMIO/debug path. Accesses are
//   gated on pool_done. Dense has priority; a starvation counter forces a CPU
//   grant after STARVE_LIMIT consecutive dense grants while cpu_req is pending.
//   Each access: IDLE (arbitrate) -> ISSUE (gnt, BRAM samples address) ->
//   CAPTURE (lane-muxed byte captured) -> rvalid in the following cycle.
//
// Ports
//   clk, resetn           clock, async active-low reset
//   pool_done             buffer readable while high
//   pool_read_addr        byte address to buffer, held from ISSUE through CAPTURE
//   pool_read_data        buffer byte, valid one cycle after address presented
//   dense_* / cpu_*       req/addr in; gnt/rvalid/rdata/rerr out per requester
//   ready                 1 while the arbiter is accepting requests
module pool2_flat_read_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH_BYTES  = 1600,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pool_done,
  output logic [ADDR_W-1:0] pool_read_addr,
  input  logic [7:0]        pool_read_data,
  input  logic              dense_req,
  input  logic [ADDR_W-1:0] dense_addr,
  output logic              dense_gnt,
  output logic              dense_rvalid,
  output logic [7:0]        dense_rdata,
  output logic              dense_rerr,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rerr,
  output logic              ready
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] DEPTH   = ADDR_W'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    WAIT_READY,
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  state_t            state_q, state_d;
  logic              win_cpu_q, win_cpu_d;
  logic              in_range_q, in_range_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              ready_q, ready_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [7:0]        d_rdata_q, d_rdata_d;
  logic              d_rerr_q, d_rerr_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic [7:0]        c_rdata_q, c_rdata_d;
  logic              c_rerr_q, c_rerr_d;

  logic              cpu_wins;
  logic              cap_err;
  logic [7:0]        cap_data;

  // Dense wins ties until the CPU has waited STARVE_LIMIT dense grants.
  assign cpu_wins = cpu_req && (!dense_req || (starve_q == CNT_MAX));

  // A pool_done drop in ISSUE is remembered in abort_q so the access still
  // errors even if pool_done has already recovered by CAPTURE.
  assign cap_err  = !in_range_q || !pool_done || abort_q;
  assign cap_data = cap_err ? 8'h00 : pool_read_data;

  always_comb begin
    state_d    = state_q;
    win_cpu_d  = win_cpu_q;
    in_range_d = in_range_q;
    abort_d    = abort_q;
    starve_d   = starve_q;
    paddr_d    = paddr_q;
    d_rvalid_d = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_rerr_d   = d_rerr_q;
    c_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    c_rerr_d   = c_rerr_q;

    case (state_q)
      WAIT_READY: begin
        if (pool_done) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!cpu_req) begin
          starve_d = '0;
        end
        if (!pool_done) begin
          state_d = WAIT_READY;
        end else if (cpu_wins) begin
          win_cpu_d  = 1'b1;
          in_range_d = (cpu_addr < DEPTH);
          paddr_d    = (cpu_addr < DEPTH) ? cpu_addr : '0;
          abort_d    = 1'b0;
          starve_d   = '0;
          state_d    = ISSUE;
        end else if (dense_req) begin
          win_cpu_d  = 1'b0;
          in_range_d = (dense_addr < DEPTH);
          paddr_d    = (dense_addr < DEPTH) ? dense_addr : '0;
          abort_d    = 1'b0;
          if (cpu_req && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
          end
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        abort_d = !pool_done;
        state_d = CAPTURE;
      end

      CAPTURE: begin
        if (win_cpu_q) begin
          c_rvalid_d = 1'b1;
          c_rdata_d  = cap_data;
          c_rerr_d   = cap_err;
        end else begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = cap_data;
          d_rerr_d   = cap_err;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = WAIT_READY;
      end
    endcase

    ready_d = (state_d != WAIT_READY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WAIT_READY;
      win_cpu_q  <= 1'b0;
      in_range_q <= 1'b0;
      abort_q    <= 1'b0;
      starve_q   <= '0;
      paddr_q    <= '0;
      ready_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_rerr_q   <= 1'b0;
      c_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      c_rerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cpu_q  <= win_cpu_d;
      in_range_q <= in_range_d;
      abort_q    <= abort_d;
      starve_q   <= starve_d;
      paddr_q    <= paddr_d;
      ready_q    <= ready_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_rerr_q   <= d_rerr_d;
      c_rvalid_q <= c_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      c_rerr_q   <= c_rerr_d;
    end
  end

  assign pool_read_addr = paddr_q;
  assign dense_gnt      = (state_q == ISSUE) && !win_cpu_q;
  assign cpu_gnt        = (state_q == ISSUE) && win_cpu_q;
  assign dense_rvalid   = d_rvalid_q;
  assign dense_rdata    = d_rdata_q;
  assign dense_rerr     = d_rerr_q;
  assign cpu_rvalid     = c_rvalid_q;
  assign cpu_rdata      = c_rdata_q;
  assign cpu_rerr       = c_rerr_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_pool2_flat_read_arbiter.sv
// tb_pool2_flat_read_arbiter
//   Directed bench for pool2_flat_read_arbiter. The pool buffer is modelled as
//   a word-wide BRAM with a registered word address and a byte-lane select on
//   the live address; buffer contents come from model_byte().
module tb_pool2_flat_read_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pool_done;
  logic [31:0] pool_read_addr;
  logic [7:0]  pool_read_data;
  logic        dense_req;
  logic [31:0] dense_addr;
  logic        dense_gnt;
  logic        dense_rvalid;
  logic [7:0]  dense_rdata;
  logic        dense_rerr;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        cpu_rerr;
  logic        ready;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  pool2_flat_read_arbiter #(
    .ADDR_W      (32),
    .DEPTH_BYTES (1600),
    .STARVE_LIMIT(8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pool_done     (pool_done),
    .pool_read_addr(pool_read_addr),
    .pool_read_data(pool_read_data),
    .dense_req     (dense_req),
    .dense_addr    (dense_addr),
    .dense_gnt     (dense_gnt),
    .dense_rvalid  (dense_rvalid),
    .dense_rdata   (dense_rdata),
    .dense_rerr    (dense_rerr),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_gnt       (cpu_gnt),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .cpu_rerr      (cpu_rerr),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = a[7:0];
    hi = a[15:8];
    return lo * 8'd37 + hi + 8'h5A;
  endfunction

  logic [29:0] bram_word_q;
  always_ff @(posedge clk) bram_word_q <= pool_read_addr[31:2];
  assign pool_read_data = model_byte({bram_word_q, pool_read_addr[1:0]});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single access from IDLE: request, bounded wait for gnt, then check the
  // two-cycle gap to rvalid with data/error from the buffer model.
  task automatic do_access(input bit cpu, input logic [31:0] addr, input int exp_wait);
    logic        oob;
    logic [31:0] exp_pa;
    logic [7:0]  exp_d;
    int          n;
    bit          got;
    oob    = (addr >= 32'd1600);
    exp_pa = oob ? 32'd0 : addr;
    exp_d  = oob ? 8'h00 : model_byte(addr);
    if (cpu) begin cpu_req = 1'b1; cpu_addr = addr; end
    else     begin dense_req = 1'b1; dense_addr = addr; end
    n = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      tick();
      n++;
      got = cpu ? cpu_gnt : dense_gnt;
    end
    chk("acc_gnt_wait", 32'(n), 32'(exp_wait));
    chk("acc_other_gnt", 32'(cpu ? dense_gnt : cpu_gnt), 32'd0);
    chk("acc_pool_addr", pool_read_addr, exp_pa);
    if (cpu) begin cpu_req = 1'b0; cpu_addr = ~addr; end
    else     begin dense_req = 1'b0; dense_addr = ~addr; end
    tick();
    chk("acc_gnt_pulse", 32'({dense_gnt, cpu_gnt}), 32'd0);
    chk("acc_rvalid_early", 32'({dense_rvalid, cpu_rvalid}), 32'd0);
    tick();
    chk("acc_rvalid", 32'({dense_rvalid, cpu_rvalid}), cpu ? 32'd1 : 32'd2);
    chk("acc_rdata", 32'(cpu ? cpu_rdata : dense_rdata), 32'(exp_d));
    chk("acc_rerr", 32'(cpu ? cpu_rerr : dense_rerr), 32'(oob));
  endtask

  initial begin
    bit seen_gnt;
    bit seen_rdy;
    bit exp_cpu;
    int n;

    resetn = 1'b0; pool_done = 1'b0;
    dense_req = 1'b0; dense_addr = '0;
    cpu_req = 1'b0; cpu_addr = '0;
    tick(); tick(); tick();
    chk("reset_flags", 32'({dense_gnt, cpu_gnt, dense_rvalid, cpu_rvalid,
                            dense_rerr, cpu_rerr, ready}), 32'd0);
    chk("reset_rdata", 32'({dense_rdata, cpu_rdata}), 32'd0);
    chk("reset_paddr", pool_read_addr, 32'd0);
    resetn = 1'b1;

    // Requests ignored until pool_done.
    cpu_req = 1'b1; cpu_addr = 32'd5;
    seen_gnt = 1'b0; seen_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_gnt |= cpu_gnt | dense_gnt;
      seen_rdy |= ready;
    end
    chk("gated_no_gnt", 32'(seen_gnt), 32'd0);
    chk("gated_not_ready", 32'(seen_rdy), 32'd0);
    pool_done = 1'b1;
    tick();
    chk("ready_rise", 32'(ready), 32'd1);
    chk("ready_no_gnt_yet", 32'(cpu_gnt), 32'd0);
    do_access(1'b1, 32'd5, 1);

    // Dense stream over 0..15 with req held: one grant every 3 cycles.
    dense_req = 1'b1; dense_addr = 32'd0;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      do begin tick(); n++; end while (!dense_gnt && n < 8);
      chk("stream_gnt_wait", 32'(n), 32'd1);
      chk("stream_paddr", pool_read_addr, 32'(i));
      if (i == 15) dense_req = 1'b0;
      else         dense_addr = 32'(i + 1);
      tick();
      chk("stream_gap", 32'({dense_gnt, dense_rvalid}), 32'd0);
      tick();
      chk("stream_rvalid", 32'(dense_rvalid), 32'd1);
      chk("stream_rdata", 32'(dense_rdata), 32'(model_byte(32'(i))));
      chk("stream_rerr", 32'(dense_rerr), 32'd0);
    end

    // Both held: 8 dense grants then one CPU grant, repeating.
    dense_req = 1'b1; dense_addr = 32'd100;
    cpu_req = 1'b1; cpu_addr = 32'd200;
    for (int k = 0; k < 18; k++) begin
      exp_cpu = ((k % 9) == 8);
      n = 0;
      do begin tick(); n++; end while (!(dense_gnt || cpu_gnt) && n < 8);
      chk("starve_gnt_wait", 32'(n), 32'd1);
      chk("starve_winner", 32'({cpu_gnt, dense_gnt}), exp_cpu ? 32'd2 : 32'd1);
      if (k == 17) begin dense_req = 1'b0; cpu_req = 1'b0; end
      tick();
      tick();
      chk("starve_rvalid", 32'({cpu_rvalid, dense_rvalid}), exp_cpu ? 32'd2 : 32'd1);
      chk("starve_rdata", 32'(exp_cpu ? cpu_rdata : dense_rdata),
          32'(model_byte(exp_cpu ? 32'd200 : 32'd100)));
    end

    // Range boundaries.
    do_access(1'b1, 32'd1600, 1);
    do_access(1'b1, 32'hFFFF_FFFF, 1);
    do_access(1'b1, 32'd1599, 1);
    do_access(1'b0, 32'd42, 1);
    do_access(1'b0, 32'd2000, 1);
    do_access(1'b0, 32'd1598, 1);

    // pool_done drops in ISSUE.
    dense_req = 1'b1; dense_addr = 32'd10;
    tick();
    chk("drop_gnt", 32'(dense_gnt), 32'd1);
    pool_done = 1'b0; dense_req = 1'b0;
    tick();
    chk("drop_rvalid_early", 32'(dense_rvalid), 32'd0);
    tick();
    chk("drop_rvalid", 32'(dense_rvalid), 32'd1);
    chk("drop_rdata", 32'(dense_rdata), 32'd0);
    chk("drop_rerr", 32'(dense_rerr), 32'd1);
    tick();
    chk("drop_not_ready", 32'(ready), 32'd0);
    cpu_req = 1'b1; cpu_addr = 32'd3;
    seen_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_gnt |= cpu_gnt;
    end
    chk("drop_no_gnt", 32'(seen_gnt), 32'd0);
    cpu_req = 1'b0;

    // Reset asserted in CAPTURE.
    pool_done = 1'b1;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    dense_req = 1'b1; dense_addr = 32'd20;
    tick();
    chk("rst_gnt", 32'(dense_gnt), 32'd1);
    dense_req = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    chk("rst_flags", 32'({dense_gnt, cpu_gnt, dense_rvalid, cpu_rvalid,
                          dense_rerr, cpu_rerr, ready}), 32'd0);
    chk("rst_rdata", 32'({dense_rdata, cpu_rdata}), 32'd0);
    chk("rst_paddr", pool_read_addr, 32'd0);
    seen_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      seen_gnt |= dense_rvalid | cpu_rvalid;
    end
    chk("rst_no_rvalid", 32'(seen_gnt), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rst_ready_again", 32'(ready), 32'd1);
    do_access(1'b0, 32'd20, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pool2_flat_read_arbiter.md
Name: pool2_flat_read_arbiter

Overview:
- Shares the single byte-addressed read port of the pool-2 flattened output buffer between two requesters: the dense-layer engine and the RISC-V MMIO/debug path.
- Accesses are gated until the pool stage reports done.
- The block hides the buffer's read timing (synchronous 1-cycle BRAM plus a byte-lane select that follows the live address) behind a simple req/gnt/rvalid handshake.
- Arbitration is dense-priority, with a starvation limit that guarantees CPU service.

Parameters:
- ADDR_W, 32, width of requester and pool read addresses.
- DEPTH_BYTES, 1600, number of valid bytes (64 ch x 5 x 5); addresses at or above this are out of range.
- STARVE_LIMIT, 8, consecutive dense grants allowed while cpu_req is pending before the CPU is forced.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pool_done  in  1  pool-stage done level; buffer is readable only while high.
- pool_read_addr  out  ADDR_W  byte address to the pool buffer read port.
- pool_read_data  in  8  byte from the pool buffer; valid one cycle after the address is presented, while that address is still held.
- dense_req  in  1  dense read request (level).
- dense_addr  in  ADDR_W  dense byte address.
- dense_gnt  out  1  one-cycle grant pulse.
- dense_rvalid  out  1  one-cycle read-data-valid pulse.
- dense_rdata  out  8  read data, valid with dense_rvalid.
- dense_rerr  out  1  error flag, qualified by dense_rvalid.
- cpu_req, cpu_addr, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_rerr: same directions, widths and meaning for the CPU path.
- ready  out  1  registered copy of pool_done gating (1 = arbiter accepting requests).

Behaviour:
- Reset (async assert, sync release):
  - State WAIT_READY.
  - All gnt, rvalid and rerr outputs are 0; both rdata are 0; pool_read_addr is 0; ready is 0.
  - Starvation counter is 0.
- States: WAIT_READY, IDLE, ISSUE, CAPTURE.
- WAIT_READY: ready=0, requests are ignored. On pool_done=1, go to IDLE with ready=1 next cycle.
- IDLE:
  - If pool_done=0, go to WAIT_READY.
  - Otherwise arbitrate on the current req levels.
  - Winner rule: CPU if cpu_req=1 and (dense_req=0 or starve_cnt==STARVE_LIMIT); otherwise dense if dense_req=1.
  - On a winner: latch the winner id and the in-range flag (addr < DEPTH_BYTES), register pool_read_addr <= winner addr (0 if out of range), then go to ISSUE.
- ISSUE (1 cycle):
  - The winner's gnt=1 for exactly this cycle.
  - pool_read_addr is held; the BRAM samples it at the end of this cycle.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - pool_read_addr is still held, so the lane mux matches the BRAM output.
  - At the cycle end, the winner's rdata <= in_range ? pool_read_data : 0, and rerr <= !in_range or pool_done==0.
  - The winner's rvalid pulses in the following cycle (IDLE).
- Latency and throughput:
  - Request seen in IDLE at cycle T: gnt at T+1, rvalid/rdata at T+3.
  - A new arbitration may occur in the same cycle as rvalid, so sustained throughput is 1 access per 3 cycles.
- Handshake rules:
  - Requesters hold req and addr stable until gnt; addr may change after gnt.
  - Dropping req before gnt cancels with no access.
  - rdata holds its last value between rvalid pulses.
  - The non-winner sees no gnt or rvalid.
- Starvation counter (saturating 0..STARVE_LIMIT):
  - Increments on each dense grant while cpu_req=1.
  - Clears on a CPU grant or whenever cpu_req=0 in IDLE.
- Out-of-range addresses keep the same 3-cycle latency, return rdata=0 with rerr=1, and drive address 0.
- If pool_done falls during ISSUE or CAPTURE, the access completes with rerr=1 and rdata=0. The block then returns via IDLE to WAIT_READY.
- Simultaneous requests resolve per the winner rule; a tie with starve_cnt < STARVE_LIMIT goes to dense.
- If reset asserts mid-access, the access is dropped: no rvalid, and all outputs return to reset values immediately.

Test Plan:
- pool_done=0, cpu_req=1, addr=5 for 20 cycles -> no cpu_gnt, ready=0. Then pool_done=1 -> ready next cycle, cpu_gnt 1 cycle after, cpu_rvalid with rdata = model byte[5], rerr=0.
- dense_req held continuously over addrs 0..15 with pool_done=1 -> 16 gnt pulses spaced 3 cycles apart, each rdata = byte[addr], lanes 0..3 correct.
- dense_req and cpu_req both held constant -> 8 dense grants, then 1 CPU grant, pattern repeating; starve_cnt clears after the CPU grant.
- cpu_addr=1600 and 0xFFFFFFFF -> cpu_rvalid 3 cycles after acceptance, rdata=0, rerr=1; dense traffic unaffected.
- pool_done dropped in the ISSUE cycle of a dense read -> dense_rvalid with rerr=1, rdata=0, then state WAIT_READY, ready=0.
- resetn asserted in CAPTURE -> no rvalid, all outputs 0 that cycle. After release with pool_done=1, the next request completes normally.
